// File: rtl/permute_pkg.sv
// Shared types, sizes and lane-index helpers for the Keccak pi permutation engine.
package permute_pkg;

  typedef enum logic [1:0] {
    LOAD,
    PERMUTE,
    DRAIN
  } fsm_t;

  localparam int unsigned NUM_ROWS  = 5;
  localparam int unsigned NUM_LANES = 25;

  // Flat index of the lane that lands in (x,y) under forward pi:
  // A'[x][y] = A[(x+3y) mod 5][x]
  function automatic int unsigned pi_fwd_src(input int unsigned x, input int unsigned y);
    return 5 * x + (x + 3 * y) % 5;
  endfunction

  // Flat index of the lane that lands in (x,y) under inverse pi:
  // A'[x][y] = A[y][(2x+3y) mod 5]
  function automatic int unsigned pi_inv_src(input int unsigned x, input int unsigned y);
    return 5 * ((2 * x + 3 * y) % 5) + y;
  endfunction

endpackage

// File: rtl/permute_engine_pi_stage.sv
// One combinational application of pi (forward or inverse) to the whole state.
module pi_stage
  import permute_pkg::*;
#(
  parameter int unsigned LANE_W = 1
) (
  input  logic                        inverse,
  input  logic [NUM_LANES*LANE_W-1:0] state_in,
  output logic [NUM_LANES*LANE_W-1:0] state_out
);

  for (genvar y = 0; y < 5; y++) begin : g_row
    for (genvar x = 0; x < 5; x++) begin : g_lane
      localparam int unsigned DST = 5 * y + x;
      localparam int unsigned FWD = pi_fwd_src(x, y);
      localparam int unsigned INV = pi_inv_src(x, y);
      assign state_out[DST*LANE_W +: LANE_W] = inverse ? state_in[INV*LANE_W +: LANE_W]
                                                       : state_in[FWD*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/permute_engine.sv
// Streaming pi permutation engine: load 5 rows, apply pi R times (one round
// per cycle), then drain 5 rows with backpressure.
module permute_engine
  import permute_pkg::*;
#(
  parameter int unsigned LANE_W     = 1,
  parameter int unsigned MAX_ROUNDS = 24,
  parameter int unsigned RW         = $clog2(MAX_ROUNDS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5*LANE_W-1:0] in_data,
  input  logic [RW-1:0]       cfg_rounds,
  input  logic                cfg_inverse,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [5*LANE_W-1:0] out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int unsigned ROW_W = 5 * LANE_W;

  fsm_t                           fsm_q, fsm_d;
  logic [2:0]                     row_cnt;
  logic [RW-1:0]                  rounds_left;
  logic                           inverse_q;
  logic [NUM_ROWS-1:0][ROW_W-1:0] st;
  logic [NUM_LANES*LANE_W-1:0]    perm;
  logic [RW-1:0]                  rounds_clamped;

  assign rounds_clamped = (32'(cfg_rounds) > MAX_ROUNDS) ? RW'(MAX_ROUNDS) : cfg_rounds;

  pi_stage #(.LANE_W(LANE_W)) u_pi (
    .inverse   (inverse_q),
    .state_in  (st),
    .state_out (perm)
  );

  assign out_data = st[row_cnt];
  assign busy     = (fsm_q != LOAD) || (row_cnt != 3'd0);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) fsm_q <= LOAD;
    else     fsm_q <= fsm_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    unique case (fsm_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && row_cnt == 3'd4)
          fsm_d = (rounds_left != '0) ? PERMUTE : DRAIN;
      end
      PERMUTE: begin
        if (rounds_left <= RW'(1)) fsm_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (row_cnt == 3'd4);
        if (out_ready && row_cnt == 3'd4) fsm_d = LOAD;
      end
      default: fsm_d = LOAD;
    endcase
  end

  // Datapath: row loading, round application and drain row counter
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt     <= '0;
      rounds_left <= '0;
      inverse_q   <= 1'b0;
      st          <= '0;
    end else begin
      unique case (fsm_q)
        LOAD: begin
          if (in_valid) begin
            st[row_cnt] <= in_data;
            row_cnt     <= (row_cnt == 3'd4) ? 3'd0 : row_cnt + 3'd1;
            if (row_cnt == 3'd0) begin
              rounds_left <= rounds_clamped;
              inverse_q   <= cfg_inverse;
            end
          end
        end
        PERMUTE: begin
          st          <= perm;
          rounds_left <= rounds_left - RW'(1);
        end
        DRAIN: begin
          if (out_ready) row_cnt <= (row_cnt == 3'd4) ? 3'd0 : row_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_permute_engine.sv
// Self-checking bench for permute_engine (LANE_W=8, MAX_ROUNDS=24).
module tb_permute_engine;

  localparam int unsigned LW  = 8;
  localparam int unsigned RWB = 5;

  typedef logic [LW-1:0] grid_t [5][5];  // indexed [x][y]

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [5*LW-1:0] in_data = '0;
  logic [RWB-1:0]  cfg_rounds = '0;
  logic            cfg_inverse = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [5*LW-1:0] out_data;
  logic            out_last;
  logic            busy;

  int checks = 0;
  int failures = 0;

  logic [5*LW-1:0] exp_q[$];
  int              exp_row = 0;
  logic [5*LW-1:0] cap[5];

  permute_engine #(.LANE_W(LW), .MAX_ROUNDS(24)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .cfg_rounds  (cfg_rounds),
    .cfg_inverse (cfg_inverse),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model written directly from the pi definitions on a 2-D grid.
  function automatic grid_t pi_once(input grid_t a, input bit inv);
    grid_t b;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        b[x][y] = inv ? a[y][(2 * x + 3 * y) % 5] : a[(x + 3 * y) % 5][x];
    return b;
  endfunction

  function automatic logic [5*LW-1:0] row_of(input grid_t a, input int y);
    logic [5*LW-1:0] r;
    for (int x = 0; x < 5; x++) r[x*LW +: LW] = a[x][y];
    return r;
  endfunction

  function automatic grid_t rand_grid();
    grid_t g;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) g[x][y] = LW'($urandom);
    return g;
  endfunction

  // Output checker: every cycle with out_valid must present the next expected row.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      exp_row = 0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        chk("out_data", 64'(out_data), 64'(exp_q[0]));
        chk("out_last", 64'(out_last), 64'(exp_row == 4));
        chk("in_ready_in_drain", 64'(in_ready), 64'd0);
        if (out_ready) begin
          void'(exp_q.pop_front());
          exp_row = (exp_row + 1) % 5;
        end
      end
    end else begin
      chk("out_last_idle", 64'(out_last), 64'd0);
    end
  end

  task automatic load_block(input grid_t g, input int unsigned r, input bit inv);
    int guard;
    for (int y = 0; y < 5; y++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = row_of(g, y);
      if (y == 0) begin
        cfg_rounds  = RWB'(r);
        cfg_inverse = inv;
      end else begin
        cfg_rounds  = RWB'($urandom_range(31));
        cfg_inverse = 1'($urandom_range(1));
      end
      guard = 0;
      while (!in_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) chk("load_timeout", 64'd1, 64'd0);
    end
    @(negedge clk);
    in_valid    = 1'b0;
    in_data     = 40'({$urandom, $urandom});
    cfg_rounds  = RWB'($urandom_range(31));
    cfg_inverse = 1'($urandom_range(1));
  endtask

  task automatic drain(input int stall);
    int got;
    int stalled;
    int guard;
    got = 0;
    stalled = 0;
    guard = 0;
    while (got < 5 && guard < 200) begin
      if (out_valid) begin
        if (stalled < stall) begin
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = 1'b1;
          cap[got] = out_data;
          got++;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    if (got < 5) chk("drain_timeout", 64'(got), 64'd5);
    chk("in_ready_after_drain", 64'(in_ready), 64'd1);
  endtask

  task automatic run_block(input grid_t g, input int unsigned r, input bit inv,
                           input int stall, input string tag);
    grid_t m;
    int unsigned rc;
    int lat;
    m  = g;
    rc = (r > 24) ? 24 : r;
    for (int unsigned i = 0; i < rc; i++) m = pi_once(m, inv);
    for (int y = 0; y < 5; y++) exp_q.push_back(row_of(m, y));
    load_block(g, r, inv);
    lat = 0;
    while (!out_valid && lat < 100) begin
      chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      in_valid = 1'b1;  // must be ignored while not in LOAD
      in_data  = 40'({$urandom, $urandom});
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(rc));
    drain(stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    grid_t g, h, m;

    // Reset held for two edges, then idle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd1);
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_out_data", 64'(out_data), 64'd0);
    end

    // Model pins: forward one-hot (1,0) -> (0,2); inverse brings it back
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) g[x][y] = '0;
    g[1][0] = 8'h01;
    m = pi_once(g, 1'b0);
    chk("model_fwd_row2", 64'(row_of(m, 2)), 64'h01);
    chk("model_fwd_row0", 64'(row_of(m, 0)), 64'h00);
    m = pi_once(m, 1'b1);
    chk("model_inv_row0", 64'(row_of(m, 0)), 64'h0100);

    // Single forward round on the one-hot
    run_block(g, 1, 1'b0, 0, "onehot");
    for (int y = 0; y < 5; y++)
      chk($sformatf("onehot_row%0d", y), 64'(cap[y]), (y == 2) ? 64'h01 : 64'h00);

    // Forward 3 then inverse 3 restores lane values 5y+x
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) g[x][y] = LW'(5 * y + x);
    run_block(g, 3, 1'b0, 0, "fwd3");
    for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) h[x][y] = cap[y][x*LW +: LW];
    run_block(h, 3, 1'b1, 0, "inv3");
    chk("roundtrip_row0", 64'(cap[0]), 64'h04_03_02_01_00);
    chk("roundtrip_row4", 64'(cap[4]), 64'h18_17_16_15_14);
    for (int y = 1; y < 4; y++)
      chk($sformatf("roundtrip_row%0d", y), 64'(cap[y]), 64'(row_of(g, y)));

    // pi has order 24; R=0 passes the state straight through
    g = rand_grid();
    run_block(g, 24, 1'b0, 0, "order24");
    for (int y = 0; y < 5; y++) chk($sformatf("order24_row%0d", y), 64'(cap[y]), 64'(row_of(g, y)));
    run_block(g, 0, 1'b0, 0, "r0");
    for (int y = 0; y < 5; y++) chk($sformatf("r0_row%0d", y), 64'(cap[y]), 64'(row_of(g, y)));

    // cfg_rounds=31 clamps to 24 (identity), with a 7-cycle output stall
    g = rand_grid();
    run_block(g, 31, 1'b1, 7, "clamp");
    for (int y = 0; y < 5; y++) chk($sformatf("clamp_row%0d", y), 64'(cap[y]), 64'(row_of(g, y)));

    // Reset during round 2 of R=10 discards the block
    g = rand_grid();
    load_block(g, 10, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);

    // Fresh block after the abort
    g = rand_grid();
    run_block(g, 5, 1'b1, 3, "post_rst");

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/permute_engine.md
# permute_engine

Parametrised, streaming successor to the single-shot permutation datapath. Loads a 5×5 state of `LANE_W`-bit lanes one row per beat over a valid/ready input stream. Applies the Keccak π lane permutation, forward or inverse, a configurable number of times at one round per cycle. Streams the result back out row by row with backpressure. Sits between the state source (file reader or upstream step) and the downstream step or file writer.

## Interface
Parameters:
- `LANE_W`, default 1: bits per lane. 1 gives the 25-bit state.
- `MAX_ROUNDS`, default 24: largest round count honoured.
- `RW`, default `$clog2(MAX_ROUNDS+1)`: width of `cfg_rounds`.

Ports:
- `clk`  input  1  the single clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  the input row beat is valid.
- `in_ready`  output  1  the engine accepts an input beat.
- `in_data`  input  5*LANE_W  one row y; lane x is at `[x*LANE_W +: LANE_W]`.
- `cfg_rounds`  input  RW  number of π applications. Sampled with row 0.
- `cfg_inverse`  input  1  0 selects forward π, 1 selects inverse π. Sampled with row 0.
- `out_valid`  output  1  the output row beat is valid.
- `out_ready`  input  1  downstream accepts the output beat.
- `out_data`  output  5*LANE_W  one output row, same layout as `in_data`.
- `out_last`  output  1  marks row 4 of the output.
- `busy`  output  1  the engine is not in LOAD, or `row_cnt` ≠ 0.

## Operation
- State storage: 25 lanes. Lane (x,y) is at `[(5y+x)*LANE_W +: LANE_W]`.
- Forward π: A'[x][y] = A[(x+3y) mod 5][x].
- Inverse π: A'[x][y] = A[y][(2x+3y) mod 5].
- FSM states:
  - LOAD: `in_ready`=1. Each handshake writes row `row_cnt` and increments `row_cnt` (range 0..4). The handshake on row 0 latches `cfg_rounds`, clamped to `MAX_ROUNDS`, into `rounds_left`, and latches `cfg_inverse`. The handshake on row 4 resets `row_cnt` to 0. It then goes to PERMUTE if `rounds_left` > 0, otherwise to DRAIN.
  - PERMUTE: `in_ready`=0 and `out_valid`=0. Each cycle the state is replaced by π(state) in the latched direction and `rounds_left` decrements. When `rounds_left`=1 the state goes to DRAIN.
  - DRAIN: `out_valid`=1. `out_data` is row `row_cnt`, and `out_last`=(`row_cnt`==4). On each handshake `row_cnt` increments. The handshake on row 4 returns to LOAD with `row_cnt`=0.
- Config inputs are ignored on rows 1–4.
- State contents do not change while DRAIN is stalled by `out_ready`=0.
- `out_data` is registered state, not a combinational function of inputs.

## Timing
- Reset values: state LOAD, `row_cnt`=0, `rounds_left`=0, state storage 0, `in_ready`=1 on the cycle after reset, `out_valid`=0, `out_last`=0, `busy`=0, `out_data`=0.
- With row 4 accepted at edge t and R = clamped rounds, `out_valid` first rises in cycle t+1+R.
  - R=0: `out_valid` rises in cycle t+1.
- Minimum block time is 5 + R + 5 cycles under continuous valid and ready.
- No overlap of load and drain: `in_ready` stays 0 from the row-4 input handshake until the cycle after the row-4 output handshake.
- `rst` during LOAD, PERMUTE or DRAIN discards the block and returns every register to its reset value at that edge.
- `cfg_rounds` > `MAX_ROUNDS` is clamped, never wrapped.
- `in_valid` while `in_ready`=0 has no effect.

## Structure
- Package `permute_pkg` holds:
  - the FSM state enum (LOAD, PERMUTE, DRAIN);
  - `NUM_ROWS`=5 and `NUM_LANES`=25;
  - the index functions `pi_fwd_src(x,y)` and `pi_inv_src(x,y)`, each returning a flat lane index.
- Sub-module `pi_stage`: combinational, parametrised by `LANE_W`.
  - Inputs: `inverse` and the full state. Output: the permuted state.
  - Instantiated once and fed back into the state register.
- Top level holds the FSM, the row and round counters, and the state register.

## Test plan
- Reset, idle: assert `rst` for 2 cycles → `in_ready`=1, `out_valid`=0 and `busy`=0 thereafter.
- Single forward round, `LANE_W`=1: load a one-hot at lane (1,0) with R=1 and inverse=0 → output has only lane (0,2) set, i.e. output row 2 = 5'b00001.
- Forward then inverse, `LANE_W`=8: run lanes loaded with value 5y+x, forward with R=3. Feed the output back with inverse=1 and R=3 → original lane values.
- Order check: R=24 forward on a random state → output equals input. R=0 → output equals input, with `out_valid` rising one cycle after row 4.
- Clamp and backpressure: `cfg_rounds`=31 with `MAX_ROUNDS`=24 behaves as R=24. Hold `out_ready`=0 for 7 cycles in DRAIN → `out_data` stable, row order 0..4 intact, `out_last` only on row 4.
- Reset mid-PERMUTE: pulse `rst` in round 2 of R=10 → next cycle `out_valid`=0 and `in_ready`=1. A fresh block then loads and produces correct output.
